// File: rtl/pr_freeze_sequencer.sv
// Freeze/soft-reset sequencer for the PR slot: drains AFU Tx traffic, freezes for
// partial reconfiguration, then unfreezes and holds the AFU in reset before running.
module pr_freeze_sequencer #(
  parameter int NUM_LINKS         = 1,
  parameter int IDLE_STABLE_CYC   = 16,
  parameter int DRAIN_TIMEOUT_CYC = 4096,
  parameter int UNFREEZE_DLY_CYC  = 8,
  parameter int RST_HOLD_CYC      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pr_req,
  input  logic                 pr_done,
  input  logic                 afu_rst_req,
  input  logic [NUM_LINKS-1:0] tx_active,
  output logic                 pr_freeze,
  output logic                 softreset,
  output logic                 pr_ready,
  output logic                 drain_timeout,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_RUN      = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_FROZEN   = 3'd3,
    ST_UNFREEZE = 3'd4,
    ST_AFU_RST  = 3'd5
  } state_t;

  localparam logic [15:0] RST_LOAD   = 16'(RST_HOLD_CYC - 1);
  localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_TIMEOUT_CYC - 1);
  localparam logic [15:0] UNF_LOAD   = 16'(UNFREEZE_DLY_CYC - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_STABLE_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idle_q, idle_d;
  logic        dto_d;
  logic        freeze_d, softreset_d, ready_d;
  logic        tx_busy;
  logic        idle_hit;

  assign tx_busy  = |tx_active;
  assign idle_hit = !tx_busy && (idle_q == IDLE_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    dto_d   = drain_timeout;

    case (state_q)
      ST_RST_HOLD, ST_AFU_RST: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 16'd1;
      end
      ST_RUN: begin
        if (pr_req) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
          idle_d  = '0;
          dto_d   = 1'b0;
        end else if (afu_rst_req) begin
          state_d = ST_AFU_RST;
          cnt_d   = RST_LOAD;
        end
      end
      ST_DRAIN: begin
        // Abort wins, then a stable idle window, then the timeout.
        if (!pr_req) begin
          state_d = ST_RUN;
        end else if (idle_hit) begin
          state_d = ST_FROZEN;
        end else if (cnt_q == '0) begin
          state_d = ST_FROZEN;
          dto_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q - 16'd1;
          idle_d = tx_busy ? '0 : idle_q + 16'd1;
        end
      end
      ST_FROZEN: begin
        if (pr_done) begin
          state_d = ST_UNFREEZE;
          cnt_d   = UNF_LOAD;
        end
      end
      ST_UNFREEZE: begin
        if (cnt_q == '0) begin
          state_d = ST_RST_HOLD;
          cnt_d   = RST_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
        cnt_d   = RST_LOAD;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    freeze_d    = (state_d == ST_FROZEN) || (state_d == ST_UNFREEZE);
    softreset_d = (state_d != ST_RUN) && (state_d != ST_DRAIN);
    ready_d     = (state_d == ST_FROZEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RST_HOLD;
      cnt_q         <= RST_LOAD;
      idle_q        <= '0;
      pr_freeze     <= 1'b0;
      softreset     <= 1'b1;
      pr_ready      <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      pr_freeze     <= freeze_d;
      softreset     <= softreset_d;
      pr_ready      <= ready_d;
      drain_timeout <= dto_d;
    end
  end

  assign state_o = state_q;

endmodule
